// File: rtl/hssb_pmii_tx_if.sv
// Application-side byte handshake into the PMII transmitter.
// The source drives byte/valid/last; the transmitter answers with ready.
interface hssb_pmii_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/hssb_pmii_tx.sv
// Nibble-wide HSSB PMII frame transmitter: preamble, SFD, then payload low nibble first,
// followed by a fixed inter-frame gap. Mid-frame starvation aborts the frame.
module hssb_pmii_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_NIBBLES    = 24,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 opb_clk,
  input  logic                 opb_rst_n,
  hssb_pmii_tx_if.slave        app,
  output logic                 hssb_pmii_tx_data0,
  output logic                 hssb_pmii_tx_data1,
  output logic                 hssb_pmii_tx_data2,
  output logic                 hssb_pmii_tx_data3,
  output logic                 hssb_pmii_tx_en,
  output logic                 tx_busy,
  output logic                 tx_underrun,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] underrun_cnt
);

  localparam int CNT_MAX = (2 * PREAMBLE_BYTES > IFG_NIBBLES) ? 2 * PREAMBLE_BYTES : IFG_NIBBLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(2 * PREAMBLE_BYTES - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_NIBBLES - 1);
  localparam logic [CW-1:0] CW_ONE   = CW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    IFG
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          ph;
  logic          ph_next;
  logic          underrun_ev;
  logic          frame_done;

  logic [7:0]    byte_q;
  logic          last_q;
  logic [7:0]    byte_d;
  logic          ready;
  logic          accept;
  logic          en_next;
  logic [3:0]    nib_next;
  logic [3:0]    data_q;

  always_ff @(posedge opb_clk or negedge opb_rst_n) begin
    if (!opb_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ph    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ph    <= ph_next;
    end
  end

  // ph marks the high-nibble cycle; a missing byte when ready is high ends the frame early.
  always_comb begin
    next_state  = state;
    cnt_next    = cnt;
    ph_next     = ~ph;
    underrun_ev = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        ph_next  = 1'b0;
        cnt_next = '0;
        if (app.tx_valid) begin
          next_state = PRE;
        end
      end
      PRE: begin
        if (cnt == PRE_LAST) begin
          next_state = SFD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW_ONE;
        end
      end
      SFD: begin
        if (ph) begin
          if (app.tx_valid) begin
            next_state = DATA;
          end else begin
            next_state  = IFG;
            ph_next     = 1'b0;
            cnt_next    = '0;
            underrun_ev = 1'b1;
          end
        end
      end
      DATA: begin
        if (ph) begin
          if (last_q) begin
            next_state = IFG;
            ph_next    = 1'b0;
            cnt_next   = '0;
            frame_done = 1'b1;
          end else if (!app.tx_valid) begin
            next_state  = IFG;
            ph_next     = 1'b0;
            cnt_next    = '0;
            underrun_ev = 1'b1;
          end
        end
      end
      IFG: begin
        ph_next = 1'b0;
        if (cnt == IFG_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW_ONE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
        ph_next    = 1'b0;
      end
    endcase
  end

  // Line outputs are precomputed from the next state so they leave a register.
  always_comb begin
    ready = 1'b0;
    case (state)
      SFD:     ready = ph;
      DATA:    ready = ph & ~last_q;
      default: ready = 1'b0;
    endcase
    tx_busy  = (state != IDLE);
    accept   = ready & app.tx_valid;
    byte_d   = accept ? app.tx_byte : byte_q;
    en_next  = 1'b0;
    nib_next = 4'h0;
    case (next_state)
      PRE: begin
        en_next  = 1'b1;
        nib_next = 4'h5;
      end
      SFD: begin
        en_next  = 1'b1;
        nib_next = ph_next ? 4'hD : 4'h5;
      end
      DATA: begin
        en_next  = 1'b1;
        nib_next = ph_next ? byte_d[7:4] : byte_d[3:0];
      end
      default: begin
        en_next  = 1'b0;
        nib_next = 4'h0;
      end
    endcase
  end

  assign app.tx_ready = ready;

  always_ff @(posedge opb_clk or negedge opb_rst_n) begin
    if (!opb_rst_n) begin
      byte_q          <= 8'h00;
      last_q          <= 1'b0;
      data_q          <= 4'h0;
      hssb_pmii_tx_en <= 1'b0;
      tx_underrun     <= 1'b0;
      frame_cnt       <= '0;
      underrun_cnt    <= '0;
    end else begin
      if (accept) begin
        byte_q <= app.tx_byte;
        last_q <= app.tx_last;
      end
      data_q          <= nib_next;
      hssb_pmii_tx_en <= en_next;
      tx_underrun     <= underrun_ev;
      if (frame_done) begin
        frame_cnt <= frame_cnt + CNT_ONE;
      end
      if (underrun_ev) begin
        underrun_cnt <= underrun_cnt + CNT_ONE;
      end
    end
  end

  assign hssb_pmii_tx_data0 = data_q[0];
  assign hssb_pmii_tx_data1 = data_q[1];
  assign hssb_pmii_tx_data2 = data_q[2];
  assign hssb_pmii_tx_data3 = data_q[3];

endmodule
